multi_bus_req_ack: RTL and testbench
====================================

Name: multi_bus_req_ack

Overview:
- Parametrised N-channel request/acknowledge responder with startup hold-off.
- Generalises the fixed two-bus, 500-cycle hold-off, ack-within-5 behaviour: channel count, hold-off length and ack latency are configurable.
- After hold-off, the channel chosen by bus_select acknowledges each rising request within a bounded, runtime-programmable latency; requests on unselected channels raise error pulses.
- Sits between bus masters and the bus-protocol assertion layer; serves as the DUT for hold-off and `always`-style property checks.

Parameters:
- NUM_CH, 2, number of request/ack channels (2..16).
- HOLDOFF, 500, cycles after reset release before requests are serviced (>=1).
- MAX_LAT, 5, maximum ack delay in cycles after the |=> cycle (0..15).
- SEL_W, max(1,$clog2(NUM_CH)), derived width of bus_select.
- LAT_W, max(1,$clog2(MAX_LAT+1)), derived width of lat_cfg.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- bus_select  in  SEL_W  index of the active channel.
- lat_cfg  in  LAT_W  requested ack delay L; clamped to MAX_LAT.
- req  in  NUM_CH  per-channel request, level.
- ack  out  NUM_CH  per-channel one-cycle ack pulse.
- ready  out  1  high once hold-off has elapsed.
- busy  out  1  a transaction is in flight.
- err_inactive  out  1  one-cycle pulse: request on an unselected channel.
- err_ch  out  SEL_W  lowest-index offending channel, valid with err_inactive.
- drop_cnt  out  8  saturating count of ignored rises on the active channel.

Behaviour:
- Reset (async assert, sync release): all outputs 0; hold-off counter 0; FSM IDLE; the previous-req register is cleared to 0.
- Hold-off: the counter increments each cycle after release. ready goes high at the edge where count reaches HOLDOFF and stays high until reset. While ready=0, req is ignored: no ack, no errors, no drops.
- Rise detection: a rise on channel c is sampled at edge T when req[c]=1 at T and req[c]=0 at T-1. The previous-req register updates every cycle, including during hold-off, so a level held high across ready going high is not a rise.
- FSM IDLE to WAIT: when ready=1 and a rise is sampled on req[bus_select] at T:
  - latch ch=bus_select and cnt=min(lat_cfg,MAX_LAT), both sampled at T;
  - busy=1 from T+1.
- WAIT: cnt decrements each cycle. ack[ch] is high exactly at edge T+1+L and low otherwise. busy drops and the FSM returns to IDLE at that same edge.
  - Net result: $rose(req[sel]) |=> ##[0:MAX_LAT] ack[sel] always holds.
- Back-to-back: a rise on the selected channel sampled at the ack edge is accepted as a new transaction.
- Rise on the active channel while in WAIT (before the ack edge): ignored; drop_cnt increments and saturates at 255.
- bus_select changes mid-transaction: the in-flight transaction completes on the latched ch. The new selection applies from the next accepted rise.
- lat_cfg changes mid-transaction: no effect until the next accepted rise.
- Inactive requests: when ready=1, any req[c]=1 (level) with c != bus_select gives err_inactive=1 at the next edge, with err_ch = lowest such c. The pulse repeats each cycle while the condition persists.
- Out-of-range bus_select (>=NUM_CH): no channel is active; every asserted req is inactive; no transactions start.
- Reset mid-transaction: ack, busy and errors clear immediately; hold-off restarts from 0.
- ack is never asserted on more than one channel, and never while ready=0.

Test Plan (NUM_CH=4, HOLDOFF=16, MAX_LAT=5):
- Hold-off: pulse req[0] at cycle 10 with bus_select=0 → no ack, drop_cnt=0. ready rises at cycle 16. A req[0] rise at cycle 20 with lat_cfg=0 → ack[0] high at cycle 21 only.
- Latency clamp: lat_cfg=7, rise on req[2] at T with bus_select=2 → ack[2] at T+6; busy high for T+1..T+5.
- Overlap/back-to-back: lat_cfg=3, rises on req[1] at T and T+2 → one ack at T+4, drop_cnt=1. A third rise at T+4 → ack at T+8.
- Select switch mid-flight: rise on req[0] at T with L=4, bus_select set to 3 at T+1 → ack[0] at T+5. req[0] held at T+6 → err_inactive=1 with err_ch=0.
- Inactive/out-of-range: bus_select=1, req[3] and req[2] high → err_inactive with err_ch=2 each cycle. bus_select=3 with req[3] rise → ack[3]. Width-limited select 5 is not reachable for NUM_CH=4; for NUM_CH=3, bus_select=3 with any req → error pulses and no ack.
- Reset mid-operation: assert reset_n=0 at T+2 of an L=5 transaction → ack never fires; ready=0; ready rises 16 cycles after release.

Source files
------------

// File: rtl/multi_bus_req_ack.sv
// multi_bus_req_ack: N-channel request/acknowledge responder.
// After a fixed startup hold-off, a rising request on the channel picked by
// bus_select is acknowledged with a one-cycle pulse after a programmable
// delay. Requests on other channels raise error pulses, and rises on the
// active channel that arrive while a transaction is in flight are counted
// as drops. reset_n asserts asynchronously. Its release is expected to be
// synchronised to clk upstream.
module multi_bus_req_ack #(
    parameter int NUM_CH  = 2,
    parameter int HOLDOFF = 500,
    parameter int MAX_LAT = 5,
    parameter int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int LAT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SEL_W-1:0]  bus_select,
    input  logic [LAT_W-1:0]  lat_cfg,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] ack,
    output logic              ready,
    output logic              busy,
    output logic              err_inactive,
    output logic [SEL_W-1:0]  err_ch,
    output logic [7:0]        drop_cnt
);

    localparam int               HC_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HC_W-1:0]  HOLD_V    = HC_W'(HOLDOFF);
    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic                ready_q, ready_d;
    logic [NUM_CH-1:0]   prev_q;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic                err_q, err_d;
    logic [SEL_W-1:0]    err_ch_q, err_ch_d;
    logic [7:0]          drop_q, drop_d;

    logic [NUM_CH-1:0]   sel_hit;
    logic [NUM_CH-1:0]   rise;
    logic [NUM_CH-1:0]   offend;
    logic                rise_sel;
    logic [LAT_W-1:0]    lat_eff;

    // Decode the selected channel, detect rises and clamp the latency request.
    // An out-of-range select matches no channel, so every request is inactive.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_hit[i] = (bus_select == SEL_W'(i));
        end
        rise     = req & ~prev_q;
        offend   = req & ~sel_hit;
        rise_sel = |(rise & sel_hit);
        lat_eff  = (lat_cfg > MAX_LAT_V) ? MAX_LAT_V : lat_cfg;
    end

    // Next-state logic: hold-off counter, transaction FSM, error and drop tracking.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ready_d  = ready_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        ack_d    = '0;
        err_d    = 1'b0;
        err_ch_d = '0;
        drop_d   = drop_q;

        if (!ready_q) begin
            // Requests are ignored entirely until the hold-off expires.
            hold_d = hold_q + HC_W'(1);
            if (hold_d == HOLD_V) begin
                ready_d = 1'b1;
            end
        end else begin
            err_d = |offend;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (offend[i]) begin
                    err_ch_d = SEL_W'(i);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (rise_sel) begin
                        ch_d = bus_select;
                        if (lat_eff == '0) begin
                            // Zero delay: acknowledge right away, never look busy.
                            ack_d = sel_hit;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = lat_eff;
                            busy_d  = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (rise_sel && (drop_q != 8'hFF)) begin
                        drop_d = drop_q + 8'd1;
                    end
                    cnt_d = cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) begin
                        // Ack goes to the latched channel, whatever bus_select is now.
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            ack_d[i] = (ch_q == SEL_W'(i));
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register. The previous-request copy runs even during hold-off so a
    // level held across ready rising is not mistaken for a rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            ready_q  <= 1'b0;
            prev_q   <= '0;
            ch_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            ready_q  <= ready_d;
            prev_q   <= req;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
            drop_q   <= drop_d;
        end
    end

    assign ack          = ack_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign err_inactive = err_q;
    assign err_ch       = err_ch_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_multi_bus_req_ack.sv
// Testbench for multi_bus_req_ack: directed scenarios followed by random
// traffic. A transaction-level reference model turns each sampled input set
// into expected ack/error events (queued with the cycle they must appear in)
// and tracks the expected ready/busy/drop levels; a monitor on the falling
// edge pops and compares whenever the DUT presents an output.
module tb_multi_bus_req_ack;

    localparam int NUM_CH  = 4;
    localparam int HOLDOFF = 16;
    localparam int MAX_LAT = 5;
    localparam int SEL_W   = 2;
    localparam int LAT_W   = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [SEL_W-1:0]  bus_select = '0;
    logic [LAT_W-1:0]  lat_cfg = '0;
    logic [NUM_CH-1:0] req = '0;
    logic [NUM_CH-1:0] ack;
    logic              ready;
    logic              busy;
    logic              err_inactive;
    logic [SEL_W-1:0]  err_ch;
    logic [7:0]        drop_cnt;

    always #5 clk = ~clk;

    multi_bus_req_ack #(
        .NUM_CH (NUM_CH),
        .HOLDOFF(HOLDOFF),
        .MAX_LAT(MAX_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_select  (bus_select),
        .lat_cfg     (lat_cfg),
        .req         (req),
        .ack         (ack),
        .ready       (ready),
        .busy        (busy),
        .err_inactive(err_inactive),
        .err_ch      (err_ch),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        int vis;
        int ch;
    } ev_t;

    ev_t ack_q[$];
    ev_t err_q[$];

    // Model state: cyc counts rising edges since reset release. Values
    // registered at edge cyc are what the monitor sees after that edge.
    int                cyc = 0;
    int                free_at = 0;
    int                b_start = 0;
    int                b_end = 0;
    int                drops = 0;
    logic [NUM_CH-1:0] prev_m = '0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NUM_CH-1:0] exp_oh;
    bit                due;
    int                exp_err;
    int                act_err;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_clear();
        cyc     = 0;
        free_at = 0;
        b_start = 0;
        b_end   = 0;
        drops   = 0;
        prev_m  = '0;
        ack_q.delete();
        err_q.delete();
    endtask

    // Apply the rules to the inputs sampled at this rising edge.
    task automatic model_eval();
        int  sel;
        int  lat;
        bit  found;
        ev_t e;
        if (!reset_n) return;
        cyc++;
        if (cyc - 1 >= HOLDOFF) begin
            sel   = int'(bus_select);
            found = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && req[c] && c != sel) begin
                    e.vis = cyc;
                    e.ch  = c;
                    err_q.push_back(e);
                    found = 1'b1;
                end
            end
            if (sel < NUM_CH && req[sel] && !prev_m[sel]) begin
                lat = (int'(lat_cfg) > MAX_LAT) ? MAX_LAT : int'(lat_cfg);
                if (cyc >= free_at) begin
                    e.vis = cyc + lat;
                    e.ch  = sel;
                    ack_q.push_back(e);
                    free_at = cyc + 1 + lat;
                    b_start = cyc;
                    b_end   = cyc + lat;
                end else if (drops < 255) begin
                    drops++;
                end
            end
        end
        prev_m = req;
    endtask

    task automatic step();
        @(posedge clk);
        model_eval();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
    endtask

    // Monitor: compare outputs half a cycle after each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            due = (ack_q.size() > 0) && (ack_q[0].vis == cyc);
            if (ack != '0 || due) begin
                exp_oh = '0;
                if (due) exp_oh[ack_q[0].ch] = 1'b1;
                check(ack == exp_oh, $sformatf("ack@%0d", cyc), int'(ack), int'(exp_oh));
                if (ack_q.size() > 0) void'(ack_q.pop_front());
            end
            due = (err_q.size() > 0) && (err_q[0].vis == cyc);
            if (err_inactive || due) begin
                exp_err = due ? (16 + err_q[0].ch) : 0;
                act_err = err_inactive ? (16 + int'(err_ch)) : 0;
                check(act_err == exp_err, $sformatf("err@%0d", cyc), act_err, exp_err);
                if (err_q.size() > 0) void'(err_q.pop_front());
            end
            check(ready == (reset_n && cyc >= HOLDOFF), $sformatf("ready@%0d", cyc),
                  int'(ready), int'(reset_n && cyc >= HOLDOFF));
            check(busy == (reset_n && cyc >= b_start && cyc < b_end), $sformatf("busy@%0d", cyc),
                  int'(busy), int'(reset_n && cyc >= b_start && cyc < b_end));
            check(int'(drop_cnt) == drops, $sformatf("drop_cnt@%0d", cyc), int'(drop_cnt), drops);
        end
    end

    // Stimulus
    initial begin
        model_clear();
        repeat (3) step();
        reset_n = 1'b1;

        // Hold-off: a request before ready is ignored, then a zero-latency ack.
        repeat (8) step();
        req[0] = 1'b1; step(); step();
        req[0] = 1'b0;
        repeat (10) step();
        lat_cfg = 3'd0;
        req[0] = 1'b1; step();
        req[0] = 1'b0;
        repeat (4) step();

        // Latency request above MAX_LAT is clamped.
        bus_select = 2'd2; lat_cfg = 3'd7;
        req[2] = 1'b1; step(); step();
        req[2] = 1'b0;
        repeat (8) step();

        // Overlapping rise is dropped; rise on the ack edge starts a new one.
        bus_select = 2'd1; lat_cfg = 3'd3;
        repeat (3) begin
            req[1] = 1'b1; step();
            req[1] = 1'b0; step();
        end
        repeat (8) step();

        // Selection switched mid-flight; the held request then becomes inactive.
        bus_select = 2'd0; lat_cfg = 3'd4;
        req[0] = 1'b1; step();
        bus_select = 2'd3;
        repeat (8) step();
        req[0] = 1'b0; step(); step();

        // Several inactive requests report the lowest channel.
        bus_select = 2'd1;
        req = 4'b1100;
        repeat (4) step();
        req = 4'b0000; step();
        bus_select = 2'd3; lat_cfg = 3'd2;
        req[3] = 1'b1; step();
        req[3] = 1'b0;
        repeat (5) step();

        // Reset in the middle of a transaction.
        bus_select = 2'd0; lat_cfg = 3'd5;
        req[0] = 1'b1; step();
        req[0] = 1'b0; step();
        do_reset();
        step(); step();
        reset_n = 1'b1;
        repeat (HOLDOFF + 4) step();

        // Saturate the drop counter with a toggling request.
        bus_select = 2'd0; lat_cfg = 3'd5;
        repeat (900) begin
            req[0] = ~req[0];
            step();
        end
        req = '0;
        repeat (8) step();

        // Random traffic with one reset in the middle.
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 5) == 0) req[c] = ~req[c];
            end
            if ($urandom_range(0, 15) == 0) bus_select = SEL_W'($urandom_range(0, NUM_CH - 1));
            lat_cfg = LAT_W'($urandom_range(0, 7));
            if (k == 700) do_reset();
            if (k == 703) reset_n = 1'b1;
            step();
        end
        req = '0;
        repeat (12) step();

        check(ack_q.size() == 0, "ack_queue_drained", ack_q.size(), 0);
        check(err_q.size() == 0, "err_queue_drained", err_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
